// File: rtl/tx_frame_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// tx_arb_pkg: shared types and defaults for tx_frame_arbiter.  Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package tx_arb_pkg;

  localparam int PULSE_W       = 17;
  localparam int CH_IDX_W      = 3;
  localparam int NUM_CH_DEF    = 4;
  localparam int MIN_GAP_DEF   = 1200;
  localparam int STALE_CYC_DEF = 120000;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CAPTURE   = 3'd1,
    ST_OFFER     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/tx_frame_arbiter_if.sv
// -----------------------------------------------------------------------------
// tx_frame_arbiter_if: channel request/payload bus plus transmitter handshake.  Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

interface tx_frame_arbiter_if #(
  parameter int NUM_CH = tx_arb_pkg::NUM_CH_DEF
) ();
  import tx_arb_pkg::*;

  logic [NUM_CH-1:0]         req;
  logic [NUM_CH*PULSE_W-1:0] pulse_id_0;
  logic [NUM_CH*PULSE_W-1:0] pulse_id_1;
  logic [NUM_CH*PULSE_W-1:0] polynomial;
  logic [NUM_CH-1:0]         ack;
  logic                      frm_valid;
  logic                      frm_ready;
  logic [CH_IDX_W-1:0]       frm_ch;
  logic [PULSE_W-1:0]        frm_data0;
  logic [PULSE_W-1:0]        frm_data1;
  logic [PULSE_W-1:0]        frm_poly;
  logic                      frm_done;
  logic                      busy;
  logic [NUM_CH-1:0]         stale;

  modport master (
    input  req, pulse_id_0, pulse_id_1, polynomial, frm_ready, frm_done,
    output ack, frm_valid, frm_ch, frm_data0, frm_data1, frm_poly, busy, stale
  );

  modport slave (
    output req, pulse_id_0, pulse_id_1, polynomial, frm_ready, frm_done,
    input  ack, frm_valid, frm_ch, frm_data0, frm_data1, frm_poly, busy, stale
  );

endinterface

`default_nettype wire

// File: rtl/tx_frame_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick: combinational round-robin search starting just above last_grant.  Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module rr_pick import tx_arb_pkg::*; #(
  parameter int NUM_CH = NUM_CH_DEF
) (
  input  logic [NUM_CH-1:0]   req,
  input  logic [CH_IDX_W-1:0] last_grant,
  output logic [CH_IDX_W-1:0] grant,
  output logic                any_req
);

  int idx;

  // Walk from the farthest offset down so the nearest requester overwrites.
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = (int'(last_grant) + i) % NUM_CH;
      if ((req & (NUM_CH'(1) << idx)) != '0) begin
        grant   = CH_IDX_W'(idx);
        any_req = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/tx_frame_arbiter.sv
// -----------------------------------------------------------------------------
// tx_frame_arbiter: round-robin sharing of one frame transmitter among NUM_CH
// decoder channels. Optional TX_ARB_STALE_DETECT_EN adds starvation flags.  Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tx_frame_arbiter import tx_arb_pkg::*; #(
  parameter int NUM_CH    = NUM_CH_DEF,
  parameter int MIN_GAP   = MIN_GAP_DEF,
  parameter int STALE_CYC = STALE_CYC_DEF
) (
  input  logic               clk_12MHz,
  input  logic               rstn,
  tx_frame_arbiter_if.master bus
);

  localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);

  arb_state_t          state;
  arb_state_t          state_nxt;
  logic [CH_IDX_W-1:0] grant;
  logic [CH_IDX_W-1:0] last_grant;
  logic [CH_IDX_W-1:0] pick;
  logic                any_req;
  logic                granted_req;
  logic                capture;
  logic [NUM_CH-1:0]   ack_vec;
  logic [GAP_W-1:0]    gap_cnt;

  rr_pick #(.NUM_CH(NUM_CH)) u_rr_pick (
    .req        (bus.req),
    .last_grant (last_grant),
    .grant      (pick),
    .any_req    (any_req)
  );

  // A grant whose request vanished before CAPTURE is withdrawn, not acked.
  assign granted_req = (bus.req & (NUM_CH'(1) << grant)) != '0;

  always_comb begin
    state_nxt = state;
    ack_vec   = '0;
    capture   = 1'b0;
    case (state)
      ST_IDLE:      if (any_req) state_nxt = ST_CAPTURE;
      ST_CAPTURE: begin
        if (granted_req) begin
          ack_vec   = NUM_CH'(1) << grant;
          capture   = 1'b1;
          state_nxt = ST_OFFER;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_OFFER:     if (bus.frm_ready) state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: if (bus.frm_done) state_nxt = (MIN_GAP > 0) ? ST_GAP : ST_IDLE;
      ST_GAP:       if (gap_cnt == GAP_LAST) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  assign bus.ack       = ack_vec;
  assign bus.frm_valid = (state == ST_OFFER);
  assign bus.busy      = (state != ST_IDLE);

  always_ff @(posedge clk_12MHz) begin
    if (!rstn) begin
      state         <= ST_IDLE;
      grant         <= '0;
      last_grant    <= CH_IDX_W'(NUM_CH - 1);
      gap_cnt       <= '0;
      bus.frm_ch    <= '0;
      bus.frm_data0 <= '0;
      bus.frm_data1 <= '0;
      bus.frm_poly  <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && any_req) grant <= pick;
      if (capture) begin
        last_grant    <= grant;
        bus.frm_ch    <= grant;
        bus.frm_data0 <= bus.pulse_id_0[int'(grant)*PULSE_W +: PULSE_W];
        bus.frm_data1 <= bus.pulse_id_1[int'(grant)*PULSE_W +: PULSE_W];
        bus.frm_poly  <= bus.polynomial[int'(grant)*PULSE_W +: PULSE_W];
      end
      gap_cnt <= (state == ST_GAP) ? gap_cnt + 1'b1 : '0;
    end
  end

`ifdef TX_ARB_STALE_DETECT_EN
  localparam int STALE_W = $clog2(STALE_CYC + 1);
  logic [NUM_CH-1:0] stale_vec;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_stale
    logic [STALE_W-1:0] wait_cnt;
    always_ff @(posedge clk_12MHz) begin
      if (!rstn) begin
        wait_cnt     <= '0;
        stale_vec[k] <= 1'b0;
      end else if (!bus.req[k] || ack_vec[k]) begin
        wait_cnt <= '0;
      end else if (wait_cnt != STALE_W'(STALE_CYC)) begin
        wait_cnt <= wait_cnt + 1'b1;
        if (wait_cnt == STALE_W'(STALE_CYC - 1)) stale_vec[k] <= 1'b1;
      end
    end
  end

  assign bus.stale = stale_vec;
`else
  assign bus.stale = '0;
`endif

endmodule

`default_nettype wire
